// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter that shares one hyperbus native memory port between
// NUM_PORTS requesters, with per-transaction grant hold, idle gap and watchdog.
module hyperbus_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int GAP_CYCLES      = 1,
    parameter int TIMEOUT         = 1024,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int MW = HBUS_DATA_WIDTH / 8
) (
    input  logic                                 hbus_clk,
    input  logic                                 hbus_rst,
    input  logic [NUM_PORTS-1:0]                 m_rrq_i,
    input  logic [NUM_PORTS-1:0]                 m_wrq_i,
    input  logic [NUM_PORTS*HBUS_ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_PORTS*HBUS_DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_PORTS*MW-1:0]              m_mask_i,
    output logic [HBUS_DATA_WIDTH-1:0]           m_dat_o,
    output logic [NUM_PORTS-1:0]                 m_valid_o,
    output logic [NUM_PORTS-1:0]                 m_ready_o,
    output logic [NUM_PORTS-1:0]                 m_gnt_o,
    output logic [HBUS_ADDR_WIDTH-1:0]           hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_o,
    output logic [MW-1:0]                        hbus_mask_o,
    output logic                                 hbus_rrq,
    output logic                                 hbus_wrq,
    input  logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_i,
    input  logic                                 hbus_ready,
    input  logic                                 hbus_valid,
    output logic [PW-1:0]                        cur_port_o,
    output logic                                 busy_o,
    output logic                                 timeout_o,
    output logic                                 err_o
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // With no gap configured a released grant goes straight back to arbitration.
    localparam state_e REL_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_e               state_q;
    logic [NUM_PORTS-1:0] gnt_q;
    logic [NUM_PORTS-1:0] mask_q;
    logic [NUM_PORTS-1:0] mask_d;
    logic [PW-1:0]        cur_port_q;
    logic [PW-1:0]        last_port_q;
    logic [WDW-1:0]       wd_cnt_q;
    logic [3:0]           gap_cnt_q;
    logic                 timeout_q;
    logic                 err_q;

    logic [NUM_PORTS-1:0] req;
    logic                 win_valid;
    logic [PW-1:0]        win_idx;
    logic                 active;
    logic                 g_rrq;
    logic                 g_wrq;

    assign req    = (m_rrq_i | m_wrq_i) & ~mask_q;
    assign active = (state_q == ST_ACTIVE);
    assign g_rrq  = m_rrq_i[cur_port_q];
    assign g_wrq  = m_wrq_i[cur_port_q];

    // Scan starts just after the last winner, so a port that just finished
    // is the last one considered.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!win_valid && req[(int'(last_port_q) + i) % NUM_PORTS]) begin
                win_valid = 1'b1;
                win_idx   = PW'((int'(last_port_q) + i) % NUM_PORTS);
            end
        end
    end

    assign mask_d = mask_q & (m_rrq_i | m_wrq_i);

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            mask_q      <= '0;
            cur_port_q  <= '0;
            last_port_q <= PW'(NUM_PORTS - 1);
            wd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            mask_q    <= mask_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_q     <= ST_ACTIVE;
                        gnt_q       <= NUM_PORTS'(1) << win_idx;
                        cur_port_q  <= win_idx;
                        last_port_q <= win_idx;
                        wd_cnt_q    <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (g_rrq && g_wrq) begin
                        err_q <= 1'b1;
                    end
                    if (!(g_rrq || g_wrq)) begin
                        state_q   <= REL_STATE;
                        gnt_q     <= '0;
                        gap_cnt_q <= '0;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_q   <= REL_STATE;
                        gnt_q     <= '0;
                        gap_cnt_q <= '0;
                        timeout_q <= 1'b1;
                        mask_q    <= mask_d | (NUM_PORTS'(1) << cur_port_q);
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes and data are a pure mux gated by ACTIVE so reset drops them at once.
    assign hbus_rrq    = active & g_rrq;
    assign hbus_wrq    = active & g_wrq & ~g_rrq;
    assign hbus_adr_o  = active ? m_adr_i[cur_port_q*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH] : '0;
    assign hbus_dat_o  = active ? m_dat_i[cur_port_q*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH] : '0;
    assign hbus_mask_o = active ? m_mask_i[cur_port_q*MW +: MW] : '0;
    assign m_valid_o   = active ? (NUM_PORTS'(hbus_valid) << cur_port_q) : '0;
    assign m_ready_o   = active ? (NUM_PORTS'(hbus_ready) << cur_port_q) : '0;
    assign m_dat_o     = hbus_dat_i;
    assign m_gnt_o     = gnt_q;
    assign cur_port_o  = cur_port_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout_q;
    assign err_o       = err_q;

endmodule
